ift_mem_arbiter: RTL and testbench

IFT_MEM_ARBITER -- requirements
Module: ift_mem_arbiter

---
 rtl/ift_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_ift_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ift_mem_arbiter.sv
// ift_mem_arbiter: two-requester (core/loader) SRAM arbiter with bounded lock and response routing.
// Define IFT_ARB_TAINT_EN to propagate taint sidebands; otherwise all taint outputs are zero.
module ift_mem_arbiter #(
   parameter int AddrWidth     = 64,
   parameter int DataWidth     = 64,
   parameter int MaxLockCycles = 16,
   parameter int StrbWidth     = DataWidth / 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [1:0]                      req_i,
   input  logic [1:0]                      lock_i,
   input  logic [1:0]                      we_i,
   input  logic [1:0][AddrWidth-1:0]       addr_i,
   input  logic [1:0][DataWidth-1:0]       wdata_i,
   input  logic [1:0][StrbWidth-1:0]       strb_i,
   output logic [1:0]                      gnt_o,
   output logic [1:0]                      rvalid_o,
   output logic [1:0][DataWidth-1:0]       rdata_o,
   input  logic [1:0]                      req_t_i,
   input  logic [1:0]                      we_t_i,
   input  logic [1:0][AddrWidth-1:0]       addr_t_i,
   input  logic [1:0][DataWidth-1:0]       wdata_t_i,
   input  logic [1:0][StrbWidth-1:0]       strb_t_i,
   output logic [1:0]                      gnt_t_o,
   output logic [1:0][DataWidth-1:0]       rdata_t_o,
   output logic                            mem_req_o,
   output logic                            mem_we_o,
   output logic [AddrWidth-1:0]            mem_addr_o,
   output logic [DataWidth-1:0]            mem_wdata_o,
   output logic [StrbWidth-1:0]            mem_strb_o,
   input  logic [DataWidth-1:0]            mem_rdata_i,
   output logic                            mem_req_t_o,
   output logic                            mem_we_t_o,
   output logic [AddrWidth-1:0]            mem_addr_t_o,
   output logic [DataWidth-1:0]            mem_wdata_t_o,
   output logic [StrbWidth-1:0]            mem_strb_t_o,
   input  logic [DataWidth-1:0]            mem_rdata_t_i
);
   localparam logic [1:0] ARB   = 2'd0;
   localparam logic [1:0] LOCK0 = 2'd1;
   localparam logic [1:0] LOCK1 = 2'd2;

   logic [1:0] state;
   logic [7:0] cnt, cnt_nxt;
   logic       last_q, rsp_valid_q, rsp_sel_q;
   logic       locked, owner, sel, any, rd_acc;

   assign locked  = state == LOCK0 || state == LOCK1;
   assign owner   = state == LOCK1;
   assign cnt_nxt = cnt + 8'd1;

   // On a tie the requester not served last wins; a lock owner excludes the other side entirely.
   always_comb
      gnt_o = rst_i ? 2'b00 : locked ? req_i & (owner ? 2'b10 : 2'b01) :
              &req_i ? (last_q ? 2'b01 : 2'b10) : req_i;

   assign sel    = gnt_o[1];
   assign any    = |gnt_o;
   assign rd_acc = any & ~we_i[sel];

   assign mem_req_o   = any;
   assign mem_we_o    = any & we_i[sel];
   assign mem_addr_o  = any ? addr_i[sel]  : '0;
   assign mem_wdata_o = any ? wdata_i[sel] : '0;
   assign mem_strb_o  = any ? strb_i[sel]  : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ARB;
         cnt         <= 8'd0;
         last_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_sel_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rd_acc;
         if (rd_acc) rsp_sel_q <= sel;
         if (any) last_q <= sel;
         if (locked) begin
            if (!lock_i[owner]) state <= ARB;
            else if (any) begin
               cnt <= cnt_nxt;
               if (cnt_nxt == 8'(MaxLockCycles)) state <= ARB;
            end
         end else if (any && lock_i[sel] && MaxLockCycles > 1) begin
            state <= sel ? LOCK1 : LOCK0;
            cnt   <= 8'd1;
         end
      end
   end

   assign rvalid_o = (rsp_valid_q & ~rst_i) ? (rsp_sel_q ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      rdata_o            = '0;
      rdata_o[rsp_sel_q] = mem_rdata_i;
   end

`ifdef IFT_ARB_TAINT_EN
   // A contested grant reveals both requesters' request taints to each side.
   assign gnt_t_o = rst_i ? 2'b00 : (!locked && &req_i) ? {2{|req_t_i}} :
                    gnt_o & {2{req_t_i[sel]}};
   assign mem_req_t_o   = any & req_t_i[sel];
   assign mem_we_t_o    = any & we_t_i[sel];
   assign mem_addr_t_o  = any ? addr_t_i[sel]  : '0;
   assign mem_wdata_t_o = any ? wdata_t_i[sel] : '0;
   assign mem_strb_t_o  = any ? strb_t_i[sel]  : '0;

   always_comb begin
      rdata_t_o = '0;
      if (!rst_i) rdata_t_o[rsp_sel_q] = mem_rdata_t_i;
   end
`else
   logic unused_taint;
   assign unused_taint  = ^{req_t_i, we_t_i, addr_t_i, wdata_t_i, strb_t_i, mem_rdata_t_i};
   assign gnt_t_o       = '0;
   assign rdata_t_o     = '0;
   assign mem_req_t_o   = 1'b0;
   assign mem_we_t_o    = 1'b0;
   assign mem_addr_t_o  = '0;
   assign mem_wdata_t_o = '0;
   assign mem_strb_t_o  = '0;
`endif
endmodule

// File: tb/tb_ift_mem_arbiter.sv
// tb_ift_mem_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter/SRAM model.
module tb_ift_mem_arbiter;
   localparam int AW = 64, DW = 64, SW = 8, MAX = 16;
`ifdef IFT_ARB_TAINT_EN
   localparam bit TAINT = 1'b1;
`else
   localparam bit TAINT = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] req = '0, lock = '0, we = '0, req_t = '0, we_t = '0;
   logic [1:0][AW-1:0] addr = '0, addr_t = '0;
   logic [1:0][DW-1:0] wdata = '0, wdata_t = '0;
   logic [1:0][SW-1:0] strb = '0, strb_t = '0;
   logic [1:0] gnt, rvalid, gnt_t;
   logic [1:0][DW-1:0] rdata, rdata_t;
   logic mem_req, mem_we, mem_req_t, mem_we_t;
   logic [AW-1:0] mem_addr, mem_addr_t;
   logic [DW-1:0] mem_wdata, mem_wdata_t, mem_rdata, mem_rdata_t = '0;
   logic [SW-1:0] mem_strb, mem_strb_t;
   logic [DW-1:0] sram [32];
   logic [DW-1:0] ref_mem [32];
   int n_cmp = 0, n_bad = 0;
   int m_lock = -1, m_cnt = 0, m_last = 0, m_rsel = 0;
   bit m_rv = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   ift_mem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxLockCycles(MAX)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .strb_i(strb), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .req_t_i(req_t), .we_t_i(we_t), .addr_t_i(addr_t), .wdata_t_i(wdata_t), .strb_t_i(strb_t),
      .gnt_t_o(gnt_t), .rdata_t_o(rdata_t), .mem_req_o(mem_req), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata),
      .mem_req_t_o(mem_req_t), .mem_we_t_o(mem_we_t), .mem_addr_t_o(mem_addr_t),
      .mem_wdata_t_o(mem_wdata_t), .mem_strb_t_o(mem_strb_t), .mem_rdata_t_i(mem_rdata_t)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [SW-1:0] s);
      merge = old;
      for (int b = 0; b < SW; b++) if (s[b]) merge[8*b +: 8] = nw[8*b +: 8];
   endfunction

   // SRAM environment: always accepts, read data one cycle later, cleared by reset.
   always @(posedge clk)
      if (rst) for (int i = 0; i < 32; i++) sram[i] <= '0;
      else if (mem_req)
         if (mem_we) sram[mem_addr[7:3]] <= merge(sram[mem_addr[7:3]], mem_wdata, mem_strb);
         else mem_rdata <= sram[mem_addr[7:3]];

   function automatic int exp_grant();
      if (rst) return -1;
      if (m_lock >= 0) return req[m_lock] ? m_lock : -1;
      if (req == 2'b11) return 1 - m_last;
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
   endfunction

   function automatic logic [1:0] oh(input int g);
      return g < 0 ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
   endfunction

   task automatic model_step();
      int g;
      g = exp_grant();
      if (rst) begin
         m_lock = -1; m_cnt = 0; m_last = 0; m_rv = 1'b0; m_rsel = 0;
         for (int i = 0; i < 32; i++) ref_mem[i] = '0;
         return;
      end
      m_rv = g >= 0 && !we[g];
      if (g >= 0) begin
         if (we[g]) ref_mem[addr[g][7:3]] = merge(ref_mem[addr[g][7:3]], wdata[g], strb[g]);
         else begin m_rdata = ref_mem[addr[g][7:3]]; m_rsel = g; end
         m_last = g;
      end
      if (m_lock < 0) begin
         if (g >= 0 && lock[g] && MAX > 1) begin m_lock = g; m_cnt = 1; end
      end else if (!lock[m_lock]) m_lock = -1;
      else if (g == m_lock) begin
         m_cnt++;
         if (m_cnt == MAX) m_lock = -1;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b11; lock = 2'b11; we = 2'b00; req_t = 2'b11; mem_rdata_t = '1;
      repeat (2) begin
         @(negedge clk);
         n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
         n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
         n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
         n_cmp++;
         if ({gnt_t, mem_req_t, |rdata_t} !== 4'b0) begin
            n_bad++; $display("FAIL reset_taint: got %b want 0000", {gnt_t, mem_req_t, |rdata_t});
         end
         advance();
      end
      rst = 1'b0; lock = 2'b00; req_t = 2'b00; mem_rdata_t = '0;
   endtask

   task automatic test_alternate();
      logic [1:0] want;
      req = 2'b11; we = 2'b00; addr[0] = 64'h08; addr[1] = 64'h10;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         want = (k % 2 == 0) ? 2'b10 : 2'b01;
         n_cmp++; if (gnt !== want) begin n_bad++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, gnt, want); end
         want = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
         n_cmp++; if (rvalid !== want) begin n_bad++; $display("FAIL alt_rvalid[%0d]: got %b want %b", k, rvalid, want); end
         advance();
      end
   endtask

   task automatic test_lock();
      logic [1:0] want;
      lock = 2'b01; we = 2'b00;
      for (int k = 0; k < 20; k++) begin
         req = (k == 0) ? 2'b01 : 2'b11;
         @(negedge clk);
         want = (k == MAX) ? 2'b10 : 2'b01;
         n_cmp++; if (gnt !== want) begin n_bad++; $display("FAIL lock_gnt[%0d]: got %b want %b", k, gnt, want); end
         advance();
      end
      lock = 2'b00;
   endtask

   task automatic test_write_read();
      req = 2'b00; lock = 2'b00;
      @(negedge clk);
      n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL wr_idle_gnt: got %b want 00", gnt); end
      advance();
      req = 2'b10; we = 2'b10; addr[1] = 64'h80; wdata[1] = 64'hDEAD; strb[1] = '1;
      @(negedge clk);
      n_cmp++;
      if ({gnt, mem_we, mem_addr} !== {2'b10, 1'b1, 64'h80}) begin
         n_bad++; $display("FAIL wr_cmd: got %b/%b/%h want 10/1/80", gnt, mem_we, mem_addr);
      end
      advance();
      req = 2'b01; we = 2'b00; addr[0] = 64'h80;
      @(negedge clk);
      n_cmp++;
      if ({gnt, rvalid} !== 4'b0100) begin
         n_bad++; $display("FAIL rd_cmd: got gnt %b rvalid %b want 01/00", gnt, rvalid);
      end
      advance();
      req = 2'b00;
      @(negedge clk);
      n_cmp++; if (rvalid !== 2'b01) begin n_bad++; $display("FAIL rd_rvalid: got %b want 01", rvalid); end
      n_cmp++; if (rdata[0] !== 64'hDEAD) begin n_bad++; $display("FAIL rd_data: got %h want dead", rdata[0]); end
      n_cmp++; if (rdata[1] !== '0) begin n_bad++; $display("FAIL rd_other: got %h want 0", rdata[1]); end
      advance();
   endtask

   task automatic test_taint();
      int g;
      req = 2'b11; lock = 2'b00; we = 2'b00; req_t = 2'b10;
      @(negedge clk);
      g = exp_grant();
      n_cmp++;
      if (gnt_t !== (TAINT ? 2'b11 : 2'b00)) begin
         n_bad++; $display("FAIL taint_tie: got %b want %b", gnt_t, TAINT ? 2'b11 : 2'b00);
      end
      n_cmp++;
      if (mem_req_t !== (TAINT & req_t[g])) begin
         n_bad++; $display("FAIL taint_mem_req: got %b want %b", mem_req_t, TAINT & req_t[g]);
      end
      advance();
      req = 2'b01; req_t = 2'b01;
      @(negedge clk);
      n_cmp++;
      if (gnt_t !== (TAINT ? 2'b01 : 2'b00)) begin
         n_bad++; $display("FAIL taint_single: got %b want %b", gnt_t, TAINT ? 2'b01 : 2'b00);
      end
      advance();
      req_t = 2'b00;
   endtask

   task automatic test_reset_mid_lock();
      req = 2'b10; lock = 2'b10; we = 2'b00; addr[1] = 64'h18;
      @(negedge clk);
      n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL rml_lock_gnt: got %b want 10", gnt); end
      advance();
      rst = 1'b1; req = 2'b11; lock = 2'b11;
      @(negedge clk);
      n_cmp++;
      if ({gnt, rvalid} !== 4'b0) begin
         n_bad++; $display("FAIL rml_in_reset: got gnt %b rvalid %b want 00/00", gnt, rvalid);
      end
      advance();
      rst = 1'b0; lock = 2'b00;
      @(negedge clk);
      n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL rml_rvalid: got %b want 00", rvalid); end
      n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL rml_tie: got %b want 10", gnt); end
      advance();
   endtask

   task automatic test_random();
      int g;
      logic [1:0] eg, ev, egt;
      logic [AW-1:0] eat;
      for (int n = 0; n < 600; n++) begin
         rst = $urandom_range(0, 59) == 0;
         req = 2'($urandom); we = 2'($urandom); req_t = 2'($urandom); we_t = 2'($urandom);
         for (int i = 0; i < 2; i++) begin
            lock[i] = $urandom_range(0, 15) != 0;
            addr[i] = 64'($urandom_range(0, 31)) << 3;
            wdata[i] = {$urandom, $urandom};
            strb[i] = 8'($urandom);
            addr_t[i] = {$urandom, $urandom};
            wdata_t[i] = {$urandom, $urandom};
            strb_t[i] = 8'($urandom);
         end
         mem_rdata_t = {$urandom, $urandom};
         @(negedge clk);
         g = exp_grant();
         eg = oh(g);
         ev = (!rst && m_rv) ? oh(m_rsel) : 2'b00;
         egt = !TAINT || rst ? 2'b00 : (m_lock < 0 && req == 2'b11) ? {2{|req_t}} :
               (g >= 0 ? eg & {2{req_t[g]}} : 2'b00);
         eat = (TAINT && g >= 0) ? addr_t[g] : '0;
         n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, gnt, eg); end
         n_cmp++; if (rvalid !== ev) begin n_bad++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, rvalid, ev); end
         if (ev != 2'b00) begin
            n_cmp++;
            if (rdata[m_rsel] !== m_rdata) begin
               n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdata[m_rsel], m_rdata);
            end
            n_cmp++;
            if (rdata_t[m_rsel] !== (TAINT ? mem_rdata_t : '0)) begin
               n_bad++; $display("FAIL rnd_rdata_t[%0d]: got %h want %h", n, rdata_t[m_rsel], TAINT ? mem_rdata_t : '0);
            end
         end
         n_cmp++;
         if (mem_req !== (g >= 0)) begin n_bad++; $display("FAIL rnd_mem_req[%0d]: got %b want %b", n, mem_req, g >= 0); end
         if (g >= 0) begin
            n_cmp++;
            if ({mem_we, mem_addr, mem_wdata, mem_strb} !== {we[g], addr[g], wdata[g], strb[g]}) begin
               n_bad++;
               $display("FAIL rnd_mem_cmd[%0d]: got %b %h %h %h want %b %h %h %h", n, mem_we, mem_addr,
                        mem_wdata, mem_strb, we[g], addr[g], wdata[g], strb[g]);
            end
         end else begin
            n_cmp++;
            if ({mem_we, mem_addr} !== '0) begin
               n_bad++; $display("FAIL rnd_mem_idle[%0d]: got %b %h want 0 0", n, mem_we, mem_addr);
            end
         end
         n_cmp++; if (gnt_t !== egt) begin n_bad++; $display("FAIL rnd_gnt_t[%0d]: got %b want %b", n, gnt_t, egt); end
         n_cmp++;
         if (mem_addr_t !== eat) begin n_bad++; $display("FAIL rnd_addr_t[%0d]: got %h want %h", n, mem_addr_t, eat); end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_lock();
      test_write_read();
      test_taint();
      test_reset_mid_lock();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
